life_board: RTL and testbench

Parametrised Game-of-Life board engine: stores an X×Y cell array, computes whole generations internally one row per clock, and applies cursor edits between generations. Successor to the rotating-shift-register board store: neighbour counting is integrated, birth/survive rules and toroidal vs. dead-border edges are selectable, and a generation counter is added. Sits between the keypad/cursor controller and the display scanner; the scanner reads `data` directly.

---
 rtl/life_pkg.sv | 23 ++
 rtl/life_row_calc.sv | 37 +++
 rtl/life_board.sv | 150 +++++++++++++++
 tb/tb_life_board.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared encodings for the Game-of-Life board engine.
//   edit_op_e : cursor edit opcodes (NOP/FLIP/SET/CLR)
//   state_e   : generation sequencer states
//   RULE_B3 / RULE_S23 : standard Conway birth/survive masks
package life_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_FLIP = 2'd1,
    OP_SET  = 2'd2,
    OP_CLR  = 2'd3
  } edit_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [8:0] RULE_B3  = 9'b000001000;
  localparam logic [8:0] RULE_S23 = 9'b000001100;

endpackage

// File: rtl/life_row_calc.sv
// life_row_calc: combinational next-state for one board row.
//   above/cur/below : pre-update rows (vertical border already resolved by caller)
//   wrap            : 1 = columns wrap around, 0 = off-board columns are dead
//   birth_mask      : bit n set -> dead cell with n neighbours is born
//   survive_mask    : bit n set -> live cell with n neighbours survives
//   new_row         : next-generation row
module life_row_calc
  import life_pkg::*;
#(
  parameter int X = 8
) (
  input  logic [X-1:0] above,
  input  logic [X-1:0] cur,
  input  logic [X-1:0] below,
  input  logic         wrap,
  input  logic [8:0]   birth_mask,
  input  logic [8:0]   survive_mask,
  output logic [X-1:0] new_row
);

  // Each row extended by one column on each side: index 0 is column -1,
  // index X+1 is column X. Cell x then sees columns x..x+2 of the extension.
  logic [X+1:0] ea, ec, eb;

  assign ea = {wrap & above[0], above, wrap & above[X-1]};
  assign ec = {wrap & cur[0],   cur,   wrap & cur[X-1]};
  assign eb = {wrap & below[0], below, wrap & below[X-1]};

  for (genvar i = 0; i < X; i++) begin : g_cell
    logic [3:0] n;
    assign n = 4'(ea[i]) + 4'(ea[i+1]) + 4'(ea[i+2]) +
               4'(ec[i])               + 4'(ec[i+2]) +
               4'(eb[i]) + 4'(eb[i+1]) + 4'(eb[i+2]);
    assign new_row[i] = cur[i] ? survive_mask[n] : birth_mask[n];
  end

endmodule

// File: rtl/life_board.sv
// life_board: X x Y Game-of-Life board, one row computed per clock.
//   step / run&tick : start a generation (IDLE only)
//   wrap, birth_mask, survive_mask : rule set, latched at generation start
//   edit_valid/edit_op/cursor_x/cursor_y : single-cell edit (IDLE only)
//   clear           : zero board and generation counter (IDLE only)
//   cmd_ready / busy / gen_done : IDLE / CALC / DONE indicators
//   gen_count       : completed generations, modulo 2^GEN_W
//   data            : board, cell (x,y) at bit y*X+x
module life_board
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             run,
  input  logic             tick,
  input  logic             wrap,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  input  logic             edit_valid,
  input  logic [1:0]       edit_op,
  input  logic [LOG2X-1:0] cursor_x,
  input  logic [LOG2Y-1:0] cursor_y,
  input  logic             clear,
  output logic             cmd_ready,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  output logic [X*Y-1:0]   data
);

  state_e           state_q, state_d;
  logic [LOG2Y-1:0] row_q;
  logic [X-1:0]     prev_row, first_row;
  logic [X-1:0]     cur_row, above_row, below_row, new_row;
  logic             wrap_q;
  logic [8:0]       birth_q, survive_q;
  logic             start, last_row, edit_hit;
  int               edit_idx, below_idx;

  assign start    = step || (run && tick);
  assign last_row = (row_q == LOG2Y'(Y-1));
  assign edit_idx = int'(cursor_y) * X + int'(cursor_x);
  assign edit_hit = edit_valid && (edit_op != OP_NOP) &&
                    (int'(cursor_x) < X) && (int'(cursor_y) < Y);

  // Rows below the current one are still untouched in data; rows above have
  // already been overwritten, so their old values come from prev_row, and
  // row 0's old value (needed by the last row when wrapping) from first_row.
  always_comb begin
    below_idx = last_row ? 0 : int'(row_q) + 1;
    cur_row   = data[int'(row_q)*X +: X];
    above_row = prev_row;
    if (row_q == '0) above_row = wrap_q ? data[(Y-1)*X +: X] : '0;
    below_row = data[below_idx*X +: X];
    if (last_row) below_row = wrap_q ? first_row : '0;
  end

  life_row_calc #(.X(X)) u_row_calc (
    .above        (above_row),
    .cur          (cur_row),
    .below        (below_row),
    .wrap         (wrap_q),
    .birth_mask   (birth_q),
    .survive_mask (survive_q),
    .new_row      (new_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Any edit_valid (even a NOP or off-board one) outranks a start request.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    gen_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (!clear && !edit_valid && start) state_d = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_row) state_d = ST_DONE;
      end
      ST_DONE: begin
        gen_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      gen_count <= '0;
      row_q     <= '0;
      prev_row  <= '0;
      first_row <= '0;
      wrap_q    <= 1'b0;
      birth_q   <= '0;
      survive_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            data      <= '0;
            gen_count <= '0;
          end else if (edit_valid) begin
            if (edit_hit) begin
              case (edit_op)
                OP_FLIP: data[edit_idx] <= ~data[edit_idx];
                OP_SET:  data[edit_idx] <= 1'b1;
                default: data[edit_idx] <= 1'b0;
              endcase
            end
          end else if (start) begin
            wrap_q    <= wrap;
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            row_q     <= '0;
          end
        end
        ST_CALC: begin
          data[int'(row_q)*X +: X] <= new_row;
          prev_row <= cur_row;
          if (row_q == '0) first_row <= cur_row;
          if (last_row) begin
            row_q     <= '0;
            gen_count <= gen_count + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_board.sv
// tb_life_board: directed checks of life_board (8x8 main instance) plus a
// 6x6 instance with a 3-bit counter for range and counter-wrap checks.
module tb_life_board;
  import life_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        step = 0, run = 0, tick = 0, wrap = 0, clear = 0;
  logic [8:0]  bm = '0, sm = '0;
  logic        ev = 0;
  logic [1:0]  eop = '0;
  logic [2:0]  cx = '0, cy = '0;
  logic        cmd_ready, busy, gen_done;
  logic [15:0] gen_count;
  logic [63:0] data;

  logic        s_step = 0, s_ev = 0;
  logic [1:0]  s_eop = '0;
  logic [2:0]  s_cx = '0, s_cy = '0;
  logic        s_ready, s_busy, s_done;
  logic [2:0]  s_gen_count;
  logic [35:0] s_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_board #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .tick(tick), .wrap(wrap),
    .birth_mask(bm), .survive_mask(sm), .edit_valid(ev), .edit_op(eop),
    .cursor_x(cx), .cursor_y(cy), .clear(clear), .cmd_ready(cmd_ready),
    .busy(busy), .gen_done(gen_done), .gen_count(gen_count), .data(data)
  );

  life_board #(.X(6), .Y(6), .LOG2X(3), .LOG2Y(3), .GEN_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .step(s_step), .run(1'b0), .tick(1'b0), .wrap(1'b1),
    .birth_mask(RULE_B3), .survive_mask(RULE_S23), .edit_valid(s_ev), .edit_op(s_eop),
    .cursor_x(s_cx), .cursor_y(s_cy), .clear(1'b0), .cmd_ready(s_ready),
    .busy(s_busy), .gen_done(s_done), .gen_count(s_gen_count), .data(s_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_edit(input logic [1:0] op, input int x, input int y);
    ev = 1; eop = op; cx = x[2:0]; cy = y[2:0];
    @(negedge clk);
    ev = 0; eop = OP_NOP;
  endtask

  task automatic do_clear();
    clear = 1; @(negedge clk); clear = 0;
  endtask

  task automatic run_gen(input string tag);
    int lat;
    step = 1; @(negedge clk); step = 0; lat = 1;
    while (!gen_done && lat < 30) begin @(negedge clk); lat++; end
    chk(tag, 64'(lat), 64'd9);
    @(negedge clk);
  endtask

  task automatic s_edit(input logic [1:0] op, input int x, input int y);
    s_ev = 1; s_eop = op; s_cx = x[2:0]; s_cy = y[2:0];
    @(negedge clk);
    s_ev = 0; s_eop = OP_NOP;
  endtask

  task automatic s_gen();
    int lat;
    s_step = 1; @(negedge clk); s_step = 0; lat = 1;
    while (!s_done && lat < 30) begin @(negedge clk); lat++; end
    chk("s_latency", 64'(lat), 64'd7);
    @(negedge clk);
  endtask

  initial begin
    logic seen_done;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 64'h0);
    chk("rst_gen", 64'(gen_count), 64'h0);
    chk("rst_ready", 64'(cmd_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(gen_done), 64'h0);
    rst_n = 1;
    @(negedge clk);

    // Blinker with exact cycle timing
    wrap = 1; bm = RULE_B3; sm = RULE_S23;
    do_edit(OP_SET, 3, 2); do_edit(OP_SET, 3, 3); do_edit(OP_SET, 3, 4);
    chk("blink_set", data, 64'h0000_0008_0808_0000);
    step = 1; @(negedge clk); step = 0;
    chk("calc1_busy", 64'(busy), 64'h1);
    chk("calc1_ready", 64'(cmd_ready), 64'h0);
    repeat (7) @(negedge clk);
    chk("calc8_busy", 64'(busy), 64'h1);
    chk("calc8_done", 64'(gen_done), 64'h0);
    @(negedge clk);
    chk("done_pulse", 64'(gen_done), 64'h1);
    chk("done_busy", 64'(busy), 64'h0);
    chk("done_ready", 64'(cmd_ready), 64'h0);
    chk("done_gen", 64'(gen_count), 64'h1);
    chk("blink_h", data, 64'h0000_0000_1C00_0000);
    @(negedge clk);
    chk("idle_ready", 64'(cmd_ready), 64'h1);
    chk("idle_done", 64'(gen_done), 64'h0);
    run_gen("blink2_lat");
    chk("blink_v", data, 64'h0000_0008_0808_0000);
    chk("blink_gen2", 64'(gen_count), 64'h2);

    // Blinker straddling both wrapped edges
    do_clear();
    chk("clr_data", data, 64'h0);
    chk("clr_gen", 64'(gen_count), 64'h0);
    do_edit(OP_SET, 0, 7); do_edit(OP_SET, 0, 0); do_edit(OP_SET, 0, 1);
    run_gen("wrapblk_lat");
    chk("wrap_blink", data, 64'h0000_0000_0000_0083);

    // Same blinker at the dead border
    do_clear();
    wrap = 0;
    do_edit(OP_SET, 0, 0); do_edit(OP_SET, 0, 1); do_edit(OP_SET, 0, 2);
    run_gen("deadblk_lat");
    chk("dead_blink", data, 64'h0000_0000_0000_0300);

    // Glider on torus: 4 gens shift by (1,1), 32 gens return home
    do_clear();
    wrap = 1;
    do_edit(OP_SET, 1, 0); do_edit(OP_SET, 2, 1);
    do_edit(OP_SET, 0, 2); do_edit(OP_SET, 1, 2); do_edit(OP_SET, 2, 2);
    chk("glider_init", data, 64'h0000_0000_0007_0402);
    repeat (4) run_gen("glider_lat");
    chk("glider_g4", data, 64'h0000_0000_0E08_0400);
    repeat (28) run_gen("glider_lat");
    chk("glider_g32", data, 64'h0000_0000_0007_0402);
    chk("glider_gen32", 64'(gen_count), 64'd32);

    // Glider into the dead-border corner becomes a block
    do_clear();
    wrap = 0;
    do_edit(OP_SET, 5, 4); do_edit(OP_SET, 6, 5);
    do_edit(OP_SET, 4, 6); do_edit(OP_SET, 5, 6); do_edit(OP_SET, 6, 6);
    chk("corner_init", data, 64'h0070_4020_0000_0000);
    repeat (4) run_gen("corner_lat");
    chk("corner_g4", data, 64'hE080_4000_0000_0000);
    repeat (3) run_gen("corner_lat");
    chk("corner_block", data, 64'hC0C0_0000_0000_0000);
    repeat (2) run_gen("corner_lat");
    chk("block_stable", data, 64'hC0C0_0000_0000_0000);
    chk("corner_gen", 64'(gen_count), 64'd9);

    // clear beats edit beats step
    clear = 1; ev = 1; eop = OP_SET; cx = 3'd5; cy = 3'd5; step = 1;
    @(negedge clk);
    clear = 0; ev = 0; step = 0;
    chk("prio_data", data, 64'h0);
    chk("prio_gen", 64'(gen_count), 64'h0);
    chk("prio_busy", 64'(busy), 64'h0);
    @(negedge clk);
    chk("prio_busy2", 64'(busy), 64'h0);
    ev = 1; eop = OP_SET; cx = 3'd4; cy = 3'd4; step = 1;
    @(negedge clk);
    ev = 0; step = 0;
    chk("edit_vs_step", data, 64'h0000_0010_0000_0000);
    chk("edit_vs_busy", 64'(busy), 64'h0);

    // step while busy is dropped
    step = 1; @(negedge clk); step = 0;
    @(negedge clk);
    step = 1; @(negedge clk); step = 0;
    begin
      int n = 0;
      while (!gen_done && n < 30) begin @(negedge clk); n++; end
      chk("busy_step_to", 64'(gen_done), 64'h1);
    end
    chk("busy_step_gen", 64'(gen_count), 64'h1);
    chk("lone_dies", data, 64'h0);
    repeat (2) @(negedge clk);
    chk("busy_step_idle", 64'(busy), 64'h0);

    // Edit ops
    do_edit(OP_FLIP, 0, 0);
    chk("flip1", data, 64'h1);
    do_edit(OP_FLIP, 0, 0);
    chk("flip2", data, 64'h0);
    do_edit(OP_SET, 7, 7);
    chk("set77", data, 64'h8000_0000_0000_0000);
    do_edit(OP_CLR, 7, 7);
    chk("clr77", data, 64'h0);
    do_edit(OP_NOP, 3, 3);
    chk("nop", data, 64'h0);

    // Reset in cycle 4 of CALC
    do_edit(OP_SET, 1, 1); do_edit(OP_SET, 2, 1);
    do_edit(OP_SET, 1, 2); do_edit(OP_SET, 2, 2);
    step = 1; @(negedge clk); step = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_data", data, 64'h0);
    chk("midrst_gen", 64'(gen_count), 64'h0);
    chk("midrst_ready", 64'(cmd_ready), 64'h1);
    rst_n = 1;
    seen_done = 0;
    repeat (12) begin @(negedge clk); seen_done |= gen_done; end
    chk("midrst_nodone", 64'(seen_done), 64'h0);

    // Free-run: five ticks, 20 cycles apart
    run = 1;
    repeat (5) begin
      repeat (19) @(negedge clk);
      tick = 1; @(negedge clk); tick = 0;
    end
    repeat (12) @(negedge clk);
    run = 0;
    chk("freerun_gen", 64'(gen_count), 64'd5);

    // 6x6 instance: off-board cursors ignored, 3-bit counter wraps
    s_edit(OP_SET, 7, 0);
    chk("s_x_oob", 64'(s_data), 64'h0);
    s_edit(OP_SET, 0, 6);
    chk("s_y_oob", 64'(s_data), 64'h0);
    s_edit(OP_SET, 5, 5);
    chk("s_set55", 64'(s_data), 64'h8_0000_0000);
    repeat (7) s_gen();
    chk("s_gen7", 64'(s_gen_count), 64'd7);
    s_gen();
    chk("s_gen_wrap", 64'(s_gen_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
